// File: rtl/uart_rx_controller.sv
// UART receive sequencer: counts oversampling edges and frame bits, strobes the
// sampler/deserializer/checkers, and reports one result pulse per completed frame.
module uart_rx_controller #(
    parameter int unsigned Data_width = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic [5:0] Prescale,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       dat_samp_en,
    output logic       deserializer_enable,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid,
    output logic       par_err_o,
    output logic       stp_err_o
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [3:0] LastData = 4'(Data_width);

    state_t     state, state_nxt;
    logic [5:0] edge_nxt;
    logic [3:0] bit_nxt;
    logic       par_en_q;
    logic [5:0] prescale_q;
    logic       frame_err, frame_err_nxt;
    logic       dv_nxt, pe_nxt, se_nxt;
    logic       bit_end;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state      <= IDLE;
            edge_cnt   <= '0;
            bit_cnt    <= '0;
            par_en_q   <= 1'b0;
            prescale_q <= '0;
            frame_err  <= 1'b0;
            data_valid <= 1'b0;
            par_err_o  <= 1'b0;
            stp_err_o  <= 1'b0;
        end else begin
            state      <= state_nxt;
            edge_cnt   <= edge_nxt;
            bit_cnt    <= bit_nxt;
            frame_err  <= frame_err_nxt;
            data_valid <= dv_nxt;
            par_err_o  <= pe_nxt;
            stp_err_o  <= se_nxt;
            if (state == IDLE) begin
                par_en_q   <= PAR_EN;
                prescale_q <= Prescale;
            end
        end
    end

    always_comb begin
        state_nxt           = state;
        edge_nxt            = edge_cnt;
        bit_nxt             = bit_cnt;
        frame_err_nxt       = frame_err;
        dv_nxt              = 1'b0;
        pe_nxt              = 1'b0;
        se_nxt              = 1'b0;
        strt_chk_en         = 1'b0;
        deserializer_enable = 1'b0;
        par_chk_en          = 1'b0;
        stp_chk_en          = 1'b0;
        dat_samp_en         = (state != IDLE);
        bit_end             = (edge_cnt == prescale_q - 6'd1);

        if (state != IDLE) begin
            edge_nxt = bit_end ? '0 : edge_cnt + 6'd1;
            if (bit_end)
                bit_nxt = bit_cnt + 4'd1;
        end

        case (state)
            IDLE: begin
                edge_nxt = '0;
                bit_nxt  = '0;
                // The IDLE cycle that sees the line low is edge 0 of the start bit,
                // so a frame occupies exactly (2+Data_width+PAR_EN)*Prescale cycles.
                if (!RX_IN) begin
                    state_nxt = START;
                    edge_nxt  = 6'd1;
                end
            end
            START: begin
                if (bit_end) begin
                    strt_chk_en = 1'b1;
                    if (strt_glitch) begin
                        state_nxt = IDLE;
                        edge_nxt  = '0;
                        bit_nxt   = '0;
                    end else begin
                        state_nxt = DATA;
                    end
                end
            end
            DATA: begin
                if (bit_end) begin
                    deserializer_enable = 1'b1;
                    if (bit_cnt == LastData)
                        state_nxt = par_en_q ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (bit_end) begin
                    par_chk_en = 1'b1;
                    state_nxt  = STOP;
                    if (par_err)
                        frame_err_nxt = 1'b1;
                end
            end
            STOP: begin
                if (bit_end) begin
                    stp_chk_en    = 1'b1;
                    state_nxt     = IDLE;
                    edge_nxt      = '0;
                    bit_nxt       = '0;
                    frame_err_nxt = 1'b0;
                    if (stp_err)
                        se_nxt = 1'b1;
                    else if (frame_err)
                        pe_nxt = 1'b1;
                    else
                        dv_nxt = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                edge_nxt  = '0;
                bit_nxt   = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_controller.sv
// Bench for uart_rx_controller: drives serial frames and compares every strobe and
// result pulse (kind, cycle, bit index) with a frame-timing model.
module tb_uart_rx_controller;

    localparam int W = 8;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       RX_IN = 1'b1;
    logic       PAR_EN = 1'b0;
    logic [5:0] Prescale = 6'd8;
    logic       strt_glitch, par_err, stp_err;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en, deserializer_enable, strt_chk_en, par_chk_en, stp_chk_en;
    logic       data_valid, par_err_o, stp_err_o;

    logic       glitch_val = 1'b0, perr_val = 1'b0, serr_val = 1'b0;
    logic [2:0] jk = '0;
    int         cyc = 0;
    int         total = 0;
    int         bad = 0;
    bit         mon_on = 1'b0;

    typedef struct packed {
        logic [3:0]  kind;
        logic [31:0] cyc;
        logic [3:0]  bc;
    } ev_t;

    ev_t obs[$];
    ev_t exp_q[$];

    uart_rx_controller #(.Data_width(W)) dut (
        .CLK(CLK), .RST(RST), .RX_IN(RX_IN), .PAR_EN(PAR_EN), .Prescale(Prescale),
        .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
        .deserializer_enable(deserializer_enable), .strt_chk_en(strt_chk_en),
        .par_chk_en(par_chk_en), .stp_chk_en(stp_chk_en), .data_valid(data_valid),
        .par_err_o(par_err_o), .stp_err_o(stp_err_o)
    );

    always #5 CLK = ~CLK;
    always @(posedge CLK) cyc <= cyc + 1;
    always @(negedge CLK) jk <= 3'($urandom);

    // Checker results are only meaningful while their strobe is high; elsewhere junk.
    assign strt_glitch = strt_chk_en ? glitch_val : jk[0];
    assign par_err     = par_chk_en  ? perr_val   : jk[1];
    assign stp_err     = stp_chk_en  ? serr_val   : jk[2];

    function automatic ev_t mk(input int k, input int c, input int b);
        return '{kind: 4'(k), cyc: 32'(c), bc: 4'(b)};
    endfunction

    always @(negedge CLK) if (mon_on) begin
        if (strt_chk_en)         obs.push_back(mk(0, cyc, int'(bit_cnt)));
        if (deserializer_enable) obs.push_back(mk(1, cyc, int'(bit_cnt)));
        if (par_chk_en)          obs.push_back(mk(2, cyc, int'(bit_cnt)));
        if (stp_chk_en)          obs.push_back(mk(3, cyc, int'(bit_cnt)));
        if (data_valid)          obs.push_back(mk(4, cyc, int'(bit_cnt)));
        if (par_err_o)           obs.push_back(mk(5, cyc, int'(bit_cnt)));
        if (stp_err_o)           obs.push_back(mk(6, cyc, int'(bit_cnt)));
    end

    task automatic tick(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    function automatic logic [5:0] legal_ps(input int sel);
        case (sel % 3)
            0:       return 6'd8;
            1:       return 6'd16;
            default: return 6'd32;
        endcase
    endfunction

    // Frame timing model: t0 is the cycle in which the idle line is first seen low;
    // frame bit b occupies cycles t0+b*p .. t0+(b+1)*p-1 and is strobed at its last cycle.
    task automatic model_frame(input int t0, input int p, input bit pe, input bit glitch,
                               input bit perr, input bit serr);
        int n;
        n = 2 + W + int'(pe);
        exp_q.push_back(mk(0, t0 + p - 1, 0));
        if (glitch) return;
        for (int b = 1; b <= W; b++) exp_q.push_back(mk(1, t0 + (b + 1) * p - 1, b));
        if (pe) exp_q.push_back(mk(2, t0 + (W + 2) * p - 1, W + 1));
        exp_q.push_back(mk(3, t0 + n * p - 1, n - 1));
        exp_q.push_back(mk(serr ? 6 : ((perr && pe) ? 5 : 4), t0 + n * p, 0));
    endtask

    task automatic send_frame(input logic [7:0] d, input int p, input bit pe,
                              input bit perr, input bit serr, input bit scr);
        logic line[$];
        Prescale = 6'(p); PAR_EN = pe;
        glitch_val = 1'b0; perr_val = perr; serr_val = serr;
        model_frame(cyc, p, pe, 1'b0, perr, serr);
        line.push_back(1'b0);
        for (int i = 0; i < W; i++) line.push_back(d[i]);
        if (pe) line.push_back(^d);
        line.push_back(1'b1);
        foreach (line[i]) begin
            RX_IN = line[i];
            for (int j = 0; j < p; j++) begin
                tick(1);
                if (scr && i == 0 && j == 0) begin
                    PAR_EN   = 1'($urandom);
                    Prescale = legal_ps(int'($urandom_range(0, 2)));
                end
            end
        end
        RX_IN = 1'b1;
    endtask

    task automatic clear_q();
        obs.delete();
        exp_q.delete();
    endtask

    task automatic test_reset();
        logic [17:0] outs;
        #1;
        outs = {edge_cnt, bit_cnt, dat_samp_en, deserializer_enable, strt_chk_en, par_chk_en,
                stp_chk_en, data_valid, par_err_o, stp_err_o};
        total++;
        if (outs !== 18'd0) begin
            bad++; $display("FAIL reset_outputs got=%h exp=0", outs);
        end
        RX_IN = 1'b0;
        tick(2);
        total++;
        if (dat_samp_en !== 1'b0 || bit_cnt !== 4'd0) begin
            bad++; $display("FAIL reset_held got samp=%b bit=%0d exp samp=0 bit=0", dat_samp_en, bit_cnt);
        end
        RX_IN = 1'b1;
        RST = 1'b1;
        mon_on = 1'b1;
        tick(4);
        total++;
        if (dat_samp_en !== 1'b0 || edge_cnt !== 6'd0) begin
            bad++; $display("FAIL idle_hold got samp=%b edge=%0d exp samp=0 edge=0", dat_samp_en, edge_cnt);
        end
        total++;
        if (obs.size() !== 0) begin
            bad++; $display("FAIL idle_no_events got=%0d exp=0", obs.size());
        end
    endtask

    task automatic test_basic();
        ev_t g;
        clear_q();
        send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(3);
        total++;
        if (obs.size() !== exp_q.size()) begin
            bad++; $display("FAIL basic_count got=%0d exp=%0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            g = (i < obs.size()) ? obs[i] : '1;
            total++;
            if (g !== exp_q[i]) begin
                bad++;
                $display("FAIL basic_ev%0d got k=%0d c=%0d b=%0d exp k=%0d c=%0d b=%0d", i,
                         g.kind, g.cyc, g.bc, exp_q[i].kind, exp_q[i].cyc, exp_q[i].bc);
            end
        end
    endtask

    task automatic test_glitch();
        ev_t g;
        clear_q();
        Prescale = 6'd8; PAR_EN = 1'b0; glitch_val = 1'b1;
        model_frame(cyc, 8, 1'b0, 1'b1, 1'b0, 1'b0);
        RX_IN = 1'b0;
        tick(2);
        RX_IN = 1'b1;
        tick(14);
        total++;
        if (obs.size() !== exp_q.size()) begin
            bad++; $display("FAIL glitch_count got=%0d exp=%0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            g = (i < obs.size()) ? obs[i] : '1;
            total++;
            if (g !== exp_q[i]) begin
                bad++;
                $display("FAIL glitch_ev%0d got k=%0d c=%0d b=%0d exp k=%0d c=%0d b=%0d", i,
                         g.kind, g.cyc, g.bc, exp_q[i].kind, exp_q[i].cyc, exp_q[i].bc);
            end
        end
        total++;
        if (dat_samp_en !== 1'b0) begin
            bad++; $display("FAIL glitch_idle got samp=%b exp=0", dat_samp_en);
        end
        glitch_val = 1'b0;
    endtask

    task automatic test_parity_err();
        ev_t g;
        clear_q();
        send_frame(8'h3E, 16, 1'b1, 1'b1, 1'b0, 1'b1);
        send_frame(8'h81, 16, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(3);
        total++;
        if (obs.size() !== exp_q.size()) begin
            bad++; $display("FAIL parity_count got=%0d exp=%0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            g = (i < obs.size()) ? obs[i] : '1;
            total++;
            if (g !== exp_q[i]) begin
                bad++;
                $display("FAIL parity_ev%0d got k=%0d c=%0d b=%0d exp k=%0d c=%0d b=%0d", i,
                         g.kind, g.cyc, g.bc, exp_q[i].kind, exp_q[i].cyc, exp_q[i].bc);
            end
        end
    endtask

    task automatic test_stop_priority();
        ev_t g;
        clear_q();
        send_frame(8'h0F, 8, 1'b1, 1'b1, 1'b1, 1'b0);
        tick(3);
        total++;
        if (obs.size() !== exp_q.size()) begin
            bad++; $display("FAIL stop_count got=%0d exp=%0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            g = (i < obs.size()) ? obs[i] : '1;
            total++;
            if (g !== exp_q[i]) begin
                bad++;
                $display("FAIL stop_ev%0d got k=%0d c=%0d b=%0d exp k=%0d c=%0d b=%0d", i,
                         g.kind, g.cyc, g.bc, exp_q[i].kind, exp_q[i].cyc, exp_q[i].bc);
            end
        end
    endtask

    task automatic test_reset_midframe();
        ev_t g;
        int k;
        logic [17:0] outs;
        clear_q();
        k = cyc;
        Prescale = 6'd8; PAR_EN = 1'b0; glitch_val = 1'b0;
        exp_q.push_back(mk(0, k + 7, 0));
        for (int b = 1; b <= 3; b++) exp_q.push_back(mk(1, k + (b + 1) * 8 - 1, b));
        RX_IN = 1'b0;
        tick(35);
        total++;
        if (bit_cnt !== 4'(35 / 8)) begin
            bad++; $display("FAIL mid_bitcnt got=%0d exp=%0d", bit_cnt, 35 / 8);
        end
        #2 RST = 1'b0;
        #1;
        outs = {edge_cnt, bit_cnt, dat_samp_en, deserializer_enable, strt_chk_en, par_chk_en,
                stp_chk_en, data_valid, par_err_o, stp_err_o};
        total++;
        if (outs !== 18'd0) begin
            bad++; $display("FAIL mid_reset_outputs got=%h exp=0", outs);
        end
        RX_IN = 1'b1;
        tick(3);
        RST = 1'b1;
        tick(2 * 8 * 11);
        total++;
        if (obs.size() !== exp_q.size()) begin
            bad++; $display("FAIL mid_count got=%0d exp=%0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            g = (i < obs.size()) ? obs[i] : '1;
            total++;
            if (g !== exp_q[i]) begin
                bad++;
                $display("FAIL mid_ev%0d got k=%0d c=%0d b=%0d exp k=%0d c=%0d b=%0d", i,
                         g.kind, g.cyc, g.bc, exp_q[i].kind, exp_q[i].cyc, exp_q[i].bc);
            end
        end
        clear_q();
        send_frame(8'h3C, 8, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(3);
        total++;
        if (obs.size() !== exp_q.size()) begin
            bad++; $display("FAIL post_reset_count got=%0d exp=%0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            g = (i < obs.size()) ? obs[i] : '1;
            total++;
            if (g !== exp_q[i]) begin
                bad++;
                $display("FAIL post_reset_ev%0d got k=%0d c=%0d b=%0d exp k=%0d c=%0d b=%0d", i,
                         g.kind, g.cyc, g.bc, exp_q[i].kind, exp_q[i].cyc, exp_q[i].bc);
            end
        end
    endtask

    task automatic test_back_to_back();
        ev_t g;
        int dv_c[$];
        int gap;
        clear_q();
        send_frame(8'h55, 32, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'hAA, 32, 1'b0, 1'b0, 1'b0, 1'b1);
        tick(3);
        total++;
        if (obs.size() !== exp_q.size()) begin
            bad++; $display("FAIL b2b_count got=%0d exp=%0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            g = (i < obs.size()) ? obs[i] : '1;
            total++;
            if (g !== exp_q[i]) begin
                bad++;
                $display("FAIL b2b_ev%0d got k=%0d c=%0d b=%0d exp k=%0d c=%0d b=%0d", i,
                         g.kind, g.cyc, g.bc, exp_q[i].kind, exp_q[i].cyc, exp_q[i].bc);
            end
        end
        foreach (obs[i]) if (obs[i].kind == 4'd4) dv_c.push_back(int'(obs[i].cyc));
        gap = (dv_c.size() == 2) ? dv_c[1] - dv_c[0] : -1;
        total++;
        if (gap !== 320) begin
            bad++; $display("FAIL b2b_spacing got=%0d exp=320 (pulses=%0d)", gap, dv_c.size());
        end
    endtask

    task automatic test_random();
        ev_t g;
        clear_q();
        for (int f = 0; f < 8; f++) begin
            send_frame(8'($urandom), int'(legal_ps(int'($urandom_range(0, 2)))),
                       1'($urandom), 1'($urandom), ($urandom_range(0, 3) == 0), 1'b1);
            tick(int'($urandom_range(0, 3)));
        end
        tick(3);
        total++;
        if (obs.size() !== exp_q.size()) begin
            bad++; $display("FAIL rand_count got=%0d exp=%0d", obs.size(), exp_q.size());
        end
        foreach (exp_q[i]) begin
            g = (i < obs.size()) ? obs[i] : '1;
            total++;
            if (g !== exp_q[i]) begin
                bad++;
                $display("FAIL rand_ev%0d got k=%0d c=%0d b=%0d exp k=%0d c=%0d b=%0d", i,
                         g.kind, g.cyc, g.bc, exp_q[i].kind, exp_q[i].cyc, exp_q[i].bc);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_glitch();
        test_parity_err();
        test_stop_priority();
        test_reset_midframe();
        test_back_to_back();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
